huffman_bit_parser: RTL and testbench
=====================================

// Module: huffman_bit_parser
// PURPOSE
//  Serial front end of the Huffman decoder. Consumes the encoded bitstream one bit per cycle,
//  MSB-first, and walks a canonical Huffman code. Emits the 5-bit frequency rank (0 = most
//  frequent) of each completed codeword. This rank drives the symbol input and the enable input
//  of the downstream rank-to-symbol look-up table.
// PARAMETERS
//  SYM_W    5   width of emitted rank (32 symbols)
//  MAX_LEN  9   longest codeword in bits; sizes code/first/len registers
//  CNT_W    16  width of optional symbol counter (HUFF_SYM_CNT_EN)
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst_n      in   1      reset, synchronous, active-low
//  flush      in   1      sync clear of partial codeword; does not clear a held symbol
//  bit_in     in   1      encoded bit, MSB of codeword first
//  bit_valid  in   1      bit_in is valid this cycle
//  bit_ready  out  1      parser accepts a bit this cycle (bit_valid & bit_ready = transfer)
//  sym_out    out  SYM_W  decoded rank; connect to LUT symbol input
//  sym_valid  out  1      sym_out holds a complete rank; connect to LUT enable
//  sym_ready  in   1      consumer takes sym_out this cycle
//  busy       out  1      partial codeword in progress (len != 0)
//  sym_count  out  CNT_W  only with HUFF_SYM_CNT_EN: completed symbols handed off
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=SHIFT; code, first, len, index cleared.
//   Outputs after reset: sym_out=0, sym_valid=0, bit_ready=1, busy=0, sym_count=0.
//  Code table (canonical, bits per length L1..L9 = 0,1,2,4,4,4,2,9,6, Kraft sum exactly 1):
//   rank0=00; 1-2=010..011; 3-6=1000..1011; 7-10=11000..11011; 11-14=111000..111011;
//   15-16=1111000..1111001; 17-25=11110100..11111100; 26-31=111111010..111111111.
//  FSM has two states.
//  SHIFT: bit_ready=1. On each accepted bit, for L = len+1:
//    c = (code<<1)|bit_in; f = first<<1 on the first bit, else (first+CNT[len])<<1;
//    idx = index + CNT[len].
//    If c - f < CNT[L]: sym_out <= idx + (c - f); sym_valid <= 1; go to HOLD.
//     Registers code, first, len, index are cleared.
//    Else code <= c, first <= f, len <= L, index <= idx.
//  HOLD: bit_ready=0, sym_valid=1, sym_out stable. On sym_ready: sym_valid <= 0; go to SHIFT.
//   The next bit is accepted the cycle after the handoff; there is no bypass.
//  Latency: sym_valid rises the cycle after the final bit of a codeword is accepted.
//   Sustained throughput is one bit per cycle, plus one stall cycle per symbol.
//  Arithmetic widths: code and first are MAX_LEN bits; subtraction is unsigned MAX_LEN bits.
//   index is SYM_W+1 bits; sym_out takes the low SYM_W bits. The table is complete, so no
//   codeword exceeds MAX_LEN and no error state exists. len==MAX_LEN always terminates.
//  bit_valid=0: no state change; partial codeword is retained indefinitely.
//  flush: clears code, first, len, index the same cycle; a bit presented that cycle is dropped.
//   In HOLD, flush leaves sym_out/sym_valid untouched. flush has priority over bit acceptance.
//  Reset mid-codeword or mid-HOLD discards everything; any held symbol is lost.
//  bit_ready depends only on state; there is no combinational path from sym_ready to bit_ready.
// CONFIGURATION
//  HUFF_SYM_CNT_EN defined: sym_count increments on each sym_valid&sym_ready handoff.
//   It saturates at 2^CNT_W-1 and clears only on reset; flush does not clear it.
//  HUFF_SYM_CNT_EN undefined: the sym_count port and its counter are absent. All other
//   behaviour is identical.
// STRUCTURE
//  Package huff_pkg: SYM_W, MAX_LEN, CNT_TABLE[1..MAX_LEN] constant (0,1,2,4,4,4,2,9,6),
//   and an enum parser_state_t {SHIFT, HOLD}.
//  Sub-module huff_canon_step (combinational):
//   inputs code, first, len, index, bit; outputs next code/first/len/index, hit, rank.
//  The top level holds the FSM, registers, handshake, and the optional counter.
// TESTING
//  1. Reset, then bits 0,0 with sym_ready=1 -> sym_out=0 and sym_valid=1 for exactly
//     one cycle, 1 cycle after the 2nd bit.
//  2. Stream 1,0,1,1 then 1,1,1,1,1,1,1,1,1 -> ranks 6 then 31 in order;
//     bit_ready=0 for the HOLD cycle between them.
//  3. Send 1,1,1,1,0,1,0,0 with sym_ready=0 for 5 cycles -> sym_out=17 held stable,
//     bit_ready=0 throughout; bits offered while held are not consumed.
//  4. Send 1,1,1 then flush, then 0,1,0 -> rank 1; the partial codeword is discarded
//     and busy drops the cycle after flush.
//  5. Assert rst_n=0 mid-codeword (after 1,1,0) and mid-HOLD -> all outputs return
//     to reset values on the next edge.
//  6. With HUFF_SYM_CNT_EN: encode all ranks 0..31 once -> sym_count=32.
//     Assert flush -> sym_count stays 32.

Source files
------------

// File: rtl/huff_pkg.sv
// Shared constants, code-length table and FSM state type for the Huffman bit parser.
// The optional symbol counter (HUFF_SYM_CNT_EN) uses CNT_W from here.
package huff_pkg;

  localparam int SYM_W   = 5;
  localparam int MAX_LEN = 9;
  localparam int CNT_W   = 16;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int IDX_W   = SYM_W + 1;

  // Number of codewords of each length; entry 0 is a zero sentinel so len==0 indexes cleanly.
  localparam logic [MAX_LEN-1:0] CNT_TABLE [0:MAX_LEN] = '{
    9'd0, 9'd0, 9'd1, 9'd2, 9'd4, 9'd4, 9'd4, 9'd2, 9'd9, 9'd6
  };

  typedef enum logic [0:0] {
    SHIFT = 1'b0,
    HOLD  = 1'b1
  } parser_state_t;

  function automatic logic [MAX_LEN-1:0] cnt_of(input logic [LEN_W-1:0] l);
    return (l <= LEN_W'(MAX_LEN)) ? CNT_TABLE[l] : '0;
  endfunction

endpackage

// File: rtl/huff_canon_step.sv
// One canonical-Huffman step: folds a new bit into the partial codeword and decides
// whether the code is complete at the new length.
module huff_canon_step
  import huff_pkg::*;
(
  input  logic [MAX_LEN-1:0] code,
  input  logic [MAX_LEN-1:0] first,
  input  logic [LEN_W-1:0]   len,
  input  logic [IDX_W-1:0]   index,
  input  logic               bit_in,
  output logic [MAX_LEN-1:0] code_nxt,
  output logic [MAX_LEN-1:0] first_nxt,
  output logic [LEN_W-1:0]   len_nxt,
  output logic [IDX_W-1:0]   index_nxt,
  output logic               hit,
  output logic [SYM_W-1:0]   rank
);

  logic [LEN_W-1:0]   l;
  logic [MAX_LEN-1:0] c, f, diff, cnt_cur, cnt_nxt;
  logic [IDX_W-1:0]   idx;

  always_comb begin
    l       = len + LEN_W'(1);
    cnt_cur = cnt_of(len);
    cnt_nxt = cnt_of(l);
    c       = (code << 1) | MAX_LEN'(bit_in);
    f       = (len == '0) ? (first << 1) : ((first + cnt_cur) << 1);
    idx     = index + IDX_W'(cnt_cur);
    // Unsigned wrap makes c < f compare as huge, so it can never look like a hit.
    diff    = c - f;
    hit     = diff < cnt_nxt;
    rank    = SYM_W'(MAX_LEN'(idx) + diff);
    if (hit) begin
      code_nxt  = '0;
      first_nxt = '0;
      len_nxt   = '0;
      index_nxt = '0;
    end else begin
      code_nxt  = c;
      first_nxt = f;
      len_nxt   = l;
      index_nxt = idx;
    end
  end

endmodule

// File: rtl/huffman_bit_parser.sv
// Serial canonical-Huffman front end: one bit per cycle in, one rank per codeword out.
// Define HUFF_SYM_CNT_EN to add the saturating sym_count port.
module huffman_bit_parser
  import huff_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [SYM_W-1:0] sym_out,
  output logic             sym_valid,
  input  logic             sym_ready,
  output logic             busy
`ifdef HUFF_SYM_CNT_EN
  ,
  output logic [CNT_W-1:0] sym_count
`endif
);

  parser_state_t      state;
  logic [MAX_LEN-1:0] code, first;
  logic [LEN_W-1:0]   len;
  logic [IDX_W-1:0]   index;

  logic [MAX_LEN-1:0] code_nxt, first_nxt;
  logic [LEN_W-1:0]   len_nxt;
  logic [IDX_W-1:0]   index_nxt;
  logic               hit;
  logic [SYM_W-1:0]   rank;

  huff_canon_step u_step (
    .code      (code),
    .first     (first),
    .len       (len),
    .index     (index),
    .bit_in    (bit_in),
    .code_nxt  (code_nxt),
    .first_nxt (first_nxt),
    .len_nxt   (len_nxt),
    .index_nxt (index_nxt),
    .hit       (hit),
    .rank      (rank)
  );

  assign bit_ready = (state == SHIFT);
  assign busy      = (len != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= SHIFT;
      code      <= '0;
      first     <= '0;
      len       <= '0;
      index     <= '0;
      sym_out   <= '0;
      sym_valid <= 1'b0;
    end else begin
      if (flush) begin
        code  <= '0;
        first <= '0;
        len   <= '0;
        index <= '0;
      end
      case (state)
        SHIFT: begin
          // flush wins: the bit presented alongside it is dropped.
          if (bit_valid && !flush) begin
            code  <= code_nxt;
            first <= first_nxt;
            len   <= len_nxt;
            index <= index_nxt;
            if (hit) begin
              sym_out   <= rank;
              sym_valid <= 1'b1;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (sym_ready) begin
            sym_valid <= 1'b0;
            state     <= SHIFT;
          end
        end
        default: state <= SHIFT;
      endcase
    end
  end

`ifdef HUFF_SYM_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      sym_count <= '0;
    else if (sym_valid && sym_ready && (sym_count != {CNT_W{1'b1}}))
      sym_count <= sym_count + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_huffman_bit_parser.sv
// Directed bench for huffman_bit_parser; the counter checks run when HUFF_SYM_CNT_EN is defined.
module tb_huffman_bit_parser;

  logic       clk = 1'b0;
  logic       rst_n, flush, bit_in, bit_valid, sym_ready;
  logic       bit_ready, sym_valid, busy;
  logic [4:0] sym_out;
`ifdef HUFF_SYM_CNT_EN
  logic [15:0] sym_count;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  huffman_bit_parser dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .sym_out   (sym_out),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .busy      (busy)
`ifdef HUFF_SYM_CNT_EN
    ,
    .sym_count (sym_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a codeword MSB-first, one bit per cycle, then idle the bit input.
  task automatic send_bits(input logic [8:0] code, input int len);
    for (int i = len - 1; i >= 0; i--) begin
      bit_in    = code[i];
      bit_valid = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  // Codewords written out straight from the canonical table.
  task automatic code_of(input int r, output logic [8:0] code, output int len);
    if      (r == 0)  begin code = 9'b00;                     len = 2; end
    else if (r <= 2)  begin code = 9'b010       + 9'(r - 1);  len = 3; end
    else if (r <= 6)  begin code = 9'b1000      + 9'(r - 3);  len = 4; end
    else if (r <= 10) begin code = 9'b11000     + 9'(r - 7);  len = 5; end
    else if (r <= 14) begin code = 9'b111000    + 9'(r - 11); len = 6; end
    else if (r <= 16) begin code = 9'b1111000   + 9'(r - 15); len = 7; end
    else if (r <= 25) begin code = 9'b11110100  + 9'(r - 17); len = 8; end
    else              begin code = 9'b111111010 + 9'(r - 26); len = 9; end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".sym_out"},   32'(sym_out),   32'd0);
    chk({tag, ".sym_valid"}, 32'(sym_valid), 32'd0);
    chk({tag, ".bit_ready"}, 32'(bit_ready), 32'd1);
    chk({tag, ".busy"},      32'(busy),      32'd0);
`ifdef HUFF_SYM_CNT_EN
    chk({tag, ".sym_count"}, 32'(sym_count), 32'd0);
`endif
  endtask

  initial begin
    logic [8:0] code;
    int         len;

    rst_n = 1'b0; flush = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; sym_ready = 1'b1;
    tick(); tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // 1: "00" -> rank 0, valid for exactly one cycle
    send_bits(9'b0, 1);
    chk("t1.busy_mid",   32'(busy),      32'd1);
    chk("t1.valid_mid",  32'(sym_valid), 32'd0);
    send_bits(9'b0, 1);
    chk("t1.valid",      32'(sym_valid), 32'd1);
    chk("t1.sym",        32'(sym_out),   32'd0);
    chk("t1.busy_clr",   32'(busy),      32'd0);
    tick();
    chk("t1.valid_drop", 32'(sym_valid), 32'd0);
    chk("t1.ready_back", 32'(bit_ready), 32'd1);

    // 2: 1011 -> 6, then 111111111 -> 31
    send_bits(9'b1011, 4);
    chk("t2.sym6",       32'(sym_out),   32'd6);
    chk("t2.valid6",     32'(sym_valid), 32'd1);
    chk("t2.hold_ready", 32'(bit_ready), 32'd0);
    tick();
    send_bits(9'b111111111, 9);
    chk("t2.sym31",      32'(sym_out),   32'd31);
    chk("t2.valid31",    32'(sym_valid), 32'd1);
    tick();
    chk("t2.valid_drop", 32'(sym_valid), 32'd0);

    // 3: 11110100 -> 17 held with sym_ready low; offered bits must not be consumed
    sym_ready = 1'b0;
    send_bits(9'b11110100, 8);
    for (int i = 0; i < 5; i++) begin
      bit_in = 1'b1; bit_valid = 1'b1;
      tick();
      chk("t3.held_sym",   32'(sym_out),   32'd17);
      chk("t3.held_valid", 32'(sym_valid), 32'd1);
      chk("t3.held_ready", 32'(bit_ready), 32'd0);
    end
    bit_valid = 1'b0;
    sym_ready = 1'b1;
    tick();
    chk("t3.release",    32'(sym_valid), 32'd0);
    chk("t3.no_consume", 32'(busy),      32'd0);

    // 4: 111, flush (with a dropped bit), then 010 -> rank 1
    send_bits(9'b111, 3);
    chk("t4.busy_pre",  32'(busy), 32'd1);
    flush = 1'b1; bit_in = 1'b0; bit_valid = 1'b1;
    tick();
    flush = 1'b0; bit_valid = 1'b0;
    chk("t4.busy_post", 32'(busy), 32'd0);
    send_bits(9'b010, 3);
    chk("t4.sym1",      32'(sym_out),   32'd1);
    chk("t4.valid1",    32'(sym_valid), 32'd1);
    tick();

    // 5: reset mid-codeword, then mid-HOLD holding rank 2
    send_bits(9'b110, 3);
    rst_n = 1'b0;
    tick();
    check_reset_outputs("t5.mid_code");
    rst_n = 1'b1;
    sym_ready = 1'b0;
    send_bits(9'b011, 3);
    chk("t5.hold_sym", 32'(sym_out), 32'd2);
    rst_n = 1'b0;
    tick();
    check_reset_outputs("t5.mid_hold");
    rst_n = 1'b1;
    sym_ready = 1'b1;

    // 6: every rank once
    for (int r = 0; r < 32; r++) begin
      code_of(r, code, len);
      send_bits(code, len);
      chk($sformatf("t6.rank%0d", r), 32'(sym_out), 32'(r));
      tick();
    end
`ifdef HUFF_SYM_CNT_EN
    chk("t6.count", 32'(sym_count), 32'd32);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t6.count_flush", 32'(sym_count), 32'd32);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
